// File: rtl/ysyx_22040895_mdu_iter.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and restoring divide.
// One result bit per CALC cycle; divide-by-zero and signed overflow resolve on accept.
module ysyx_22040895_mdu_iter #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned WORD_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      mduop_i,
    input  logic            wordop_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            flush_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result_o
);
    localparam int unsigned CNT_W = $clog2(XLEN + 1);
    localparam int unsigned PRD_W = 2 * XLEN;

    localparam logic [3:0] OP_MUL    = 4'd1;
    localparam logic [3:0] OP_MULH   = 4'd2;
    localparam logic [3:0] OP_MULHSU = 4'd3;
    localparam logic [3:0] OP_MULHU  = 4'd4;
    localparam logic [3:0] OP_DIV    = 4'd5;
    localparam logic [3:0] OP_DIVU   = 4'd6;
    localparam logic [3:0] OP_REM    = 4'd7;
    localparam logic [3:0] OP_REMU   = 4'd8;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Extend the low WORD_W bits to XLEN, sign- or zero-filling above.
    function automatic logic [XLEN-1:0] ext_w(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] r;
        for (int i = 0; i < int'(XLEN); i++)
            r[i] = (i < int'(WORD_W)) ? v[i] : (sgn & v[WORD_W-1]);
        return r;
    endfunction

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        op_q;
    logic              word_q, is_div_q, neg_q, rem_neg_q;
    logic [PRD_W-1:0]  acc, mcand;
    logic [XLEN-1:0]   mplr, quo, rem;

    logic              op_legal_c, is_div_c, word_c, sgn_a_c, sgn_b_c;
    logic              a_neg_c, b_neg_c, div0_c, ovf_c;
    logic [XLEN-1:0]   a_ext_c, b_ext_c, a_mag_c, b_mag_c, min_c, spec_c;

    // Request decode: effective operands, magnitudes and special-case results.
    always_comb begin
        op_legal_c = (mduop_i >= OP_MUL) && (mduop_i <= OP_REMU);
        is_div_c   = mduop_i >= OP_DIV;
        word_c     = wordop_i && ((mduop_i == OP_MUL) || is_div_c);
        sgn_a_c    = mduop_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        sgn_b_c    = mduop_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        a_ext_c    = word_c ? ext_w(op1_i, sgn_a_c) : op1_i;
        b_ext_c    = word_c ? ext_w(op2_i, sgn_b_c) : op2_i;
        a_neg_c    = sgn_a_c & a_ext_c[XLEN-1];
        b_neg_c    = sgn_b_c & b_ext_c[XLEN-1];
        a_mag_c    = a_neg_c ? -a_ext_c : a_ext_c;
        b_mag_c    = b_neg_c ? -b_ext_c : b_ext_c;
        min_c      = word_c ? ext_w(XLEN'(1) << (WORD_W - 1), 1'b1)
                            : XLEN'(1) << (XLEN - 1);
        div0_c     = is_div_c && (b_ext_c == '0);
        ovf_c      = ((mduop_i == OP_DIV) || (mduop_i == OP_REM)) &&
                     (a_ext_c == min_c) && (b_ext_c == '1);
        if ((mduop_i == OP_REM) || (mduop_i == OP_REMU))
            spec_c = div0_c ? a_ext_c : '0;
        else
            spec_c = div0_c ? '1 : a_ext_c;
        if (word_c)
            spec_c = ext_w(spec_c, 1'b1);
    end

    logic [PRD_W-1:0]  acc_nxt_c, prod_c;
    logic [XLEN:0]     rem_sh_c;
    logic              ge_c;
    logic [XLEN-1:0]   rem_nxt_c, quo_nxt_c, quo_f_c, rem_f_c, raw_c, fin_c;

    // One iteration step plus sign correction of the finished value.
    always_comb begin
        acc_nxt_c = mplr[0] ? acc + mcand : acc;
        rem_sh_c  = {rem, quo[XLEN-1]};
        ge_c      = rem_sh_c >= {1'b0, mplr};
        rem_nxt_c = ge_c ? XLEN'(rem_sh_c - {1'b0, mplr}) : rem_sh_c[XLEN-1:0];
        quo_nxt_c = {quo[XLEN-2:0], ge_c};
        prod_c    = neg_q ? -acc_nxt_c : acc_nxt_c;
        quo_f_c   = neg_q ? -quo_nxt_c : quo_nxt_c;
        rem_f_c   = rem_neg_q ? -rem_nxt_c : rem_nxt_c;
        case (op_q)
            OP_MUL:                       raw_c = prod_c[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: raw_c = prod_c[PRD_W-1:XLEN];
            OP_DIV, OP_DIVU:              raw_c = quo_f_c;
            default:                      raw_c = rem_f_c;
        endcase
        fin_c = word_q ? ext_w(raw_c, 1'b1) : raw_c;
    end

    // Control FSM and datapath registers; flush beats accept and drain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            result_o  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            op_q      <= '0;
            word_q    <= 1'b0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplr      <= '0;
            quo       <= '0;
            rem       <= '0;
        end else if (flush_i) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready && op_legal_c) begin
                        op_q      <= mduop_i;
                        word_q    <= word_c;
                        is_div_q  <= is_div_c;
                        neg_q     <= a_neg_c ^ b_neg_c;
                        rem_neg_q <= a_neg_c;
                        acc       <= '0;
                        mcand     <= PRD_W'(a_mag_c);
                        mplr      <= b_mag_c;
                        rem       <= '0;
                        // Left-align a word dividend so the MSB-first loop runs WORD_W steps.
                        quo       <= word_c ? (a_mag_c << (XLEN - WORD_W)) : a_mag_c;
                        cnt       <= word_c ? CNT_W'(WORD_W) : CNT_W'(XLEN);
                        in_ready  <= 1'b0;
                        if (div0_c || ovf_c) begin
                            result_o  <= spec_c;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_nxt_c;
                    mcand <= mcand << 1;
                    if (!is_div_q)
                        mplr <= mplr >> 1;
                    rem   <= rem_nxt_c;
                    quo   <= quo_nxt_c;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result_o  <= fin_c;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040895_mdu_iter.sv
// Directed bench for ysyx_22040895_mdu_iter: vector table plus handshake, flush and reset sequences.
module tb_ysyx_22040895_mdu_iter;
    localparam logic [3:0] MUL = 4'd1, MULH = 4'd2, MULHSU = 4'd3, MULHU = 4'd4;
    localparam logic [3:0] DIV = 4'd5, DIVU = 4'd6, REM = 4'd7, REMU = 4'd8;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk, rst, in_valid, in_ready, wordop, flush, out_valid, out_ready;
    logic [3:0]  mduop;
    logic [63:0] op1, op2, result;

    int n_vec = 0;
    int n_err = 0;

    ysyx_22040895_mdu_iter #(.XLEN(64), .WORD_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mduop_i   (mduop),
        .wordop_i  (wordop),
        .op1_i     (op1),
        .op2_i     (op2),
        .flush_i   (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_o  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lat = clock edges from the accepting edge (inclusive) until out_valid is first seen high.
    typedef struct {
        logic [3:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        int          lat;
        string       name;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [3:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] res, input int lat,
                       input string name);
        vec_t v;
        v.op = op; v.w = w; v.a = a; v.b = b; v.res = res; v.lat = lat; v.name = name;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b);
        in_valid = 1'b1; mduop = op; wordop = w; op1 = a; op2 = b;
    endtask

    // Wait (bounded) for out_valid after an accept edge already taken; returns edge count.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] res, input int lat,
                          input string name);
        int cyc;
        @(negedge clk);
        drive(op, w, a, b);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(cyc);
        chk({name, " latency"}, 64'(cyc), 64'(lat));
        chk({name, " result"}, result, res);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, " drained"}, {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic seen;

        add(MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, "mul_7x-3");
        add(DIV,    1'b1, 64'd5, 64'd0, ONES, 1, "divw_by0");
        add(REMU,   1'b1, 64'd5, 64'd0, 64'd5, 1, "remuw_by0");
        add(DIV,    1'b0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 1, "div_ovf");
        add(REM,    1'b0, 64'h8000_0000_0000_0000, ONES, 64'd0, 1, "rem_ovf");
        add(REMU,   1'b0, 64'd100, 64'd7, 64'd2, 65, "remu_100_7");
        add(MULHU,  1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu_max");
        add(DIV,    1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 33, "divw_-20_3");
        add(REM,    1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 33, "remw_-20_3");
        add(MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, ONES, 65, "mulh_-2x3");
        add(MULHSU, 1'b0, ONES, ONES, ONES, 65, "mulhsu_-1xmax");
        add(MUL,    1'b1, 64'h1234_5678_7FFF_FFFF, 64'hABCD_0000_0000_0002,
            64'hFFFF_FFFF_FFFF_FFFE, 33, "mulw_trunc");
        add(DIVU,   1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33, "divuw_sext");
        add(DIV,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_7_-2");
        add(REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65, "rem_-7_2");
        add(DIVU,   1'b0, 64'h8000_0000_0000_0000, ONES, 64'd0, 65, "divu_big");
        add(MULHU,  1'b1, ONES, 64'd2, 64'd1, 65, "mulhu_w_ignored");
        add(DIV,    1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 1, "divw_ovf");
        add(DIV,    1'b0, 64'd5, 64'd0, ONES, 1, "div_by0");
        add(REM,    1'b1, 64'h0000_0000_FFFF_FFF9, 64'h0000_0001_0000_0000,
            64'hFFFF_FFFF_FFFF_FFF9, 1, "remw_by0_eff");
        add(MUL,    1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 64'd0, 33, "mulw_min2");

        rst = 1'b0; in_valid = 1'b0; mduop = 4'd0; wordop = 1'b0;
        op1 = '0; op2 = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tv[i])
            run_op(tv[i].op, tv[i].w, tv[i].a, tv[i].b, tv[i].res, tv[i].lat, tv[i].name);

        // Illegal opcodes are never accepted.
        @(negedge clk);
        drive(4'd0, 1'b0, 64'd1, 64'd1);
        @(posedge clk); #1;
        chk("illegal op0 in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        mduop = 4'd9;
        @(posedge clk); #1;
        chk("illegal op9 in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        mduop = 4'd15;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("illegal op15 in_ready", 64'(in_ready), 64'd1);
        chk("illegal out_valid", 64'(out_valid), 64'd0);

        // Result held while the consumer stalls.
        @(negedge clk);
        drive(REMU, 1'b0, 64'd100, 64'd7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(cyc);
        chk("stall latency", 64'(cyc), 64'd65);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall hold flags", {62'd0, out_valid, in_ready}, 64'd2);
            chk("stall hold result", result, 64'd2);
        end

        // Drain edge must not accept a request presented in the same cycle.
        @(negedge clk);
        out_ready = 1'b1;
        drive(MUL, 1'b0, 64'd3, 64'd5);
        @(posedge clk); #1;
        chk("drain no-accept in_ready", 64'(in_ready), 64'd1);
        chk("drain out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("post-drain accept", 64'(in_ready), 64'd0);
        wait_done(cyc);
        chk("post-drain mul latency", 64'(cyc), 64'd65);
        chk("post-drain mul result", result, 64'd15);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Flush at CALC cycle 20 of a DIV; a simultaneous request is ignored.
        @(negedge clk);
        drive(DIV, 1'b0, 64'd1000, 64'd7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        drive(MUL, 1'b0, 64'd2, 64'd2);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush in_ready", 64'(in_ready), 64'd1);
        chk("flush out_valid", 64'(out_valid), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        chk("flush no result", 64'(seen), 64'd0);
        chk("flush idle after", 64'(in_ready), 64'd1);

        // Reset for one cycle during CALC of a DIVW.
        @(negedge clk);
        drive(DIV, 1'b1, 64'd100, 64'd7);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midreset out_valid", 64'(out_valid), 64'd0);
        chk("midreset in_ready", 64'(in_ready), 64'd1);
        chk("midreset result", result, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        chk("midreset no result", 64'(seen), 64'd0);
        run_op(DIV, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 33,
               "divw_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_22040895_mdu_iter.md
YSYX_22040895_MDU_ITER -- requirements
Module: ysyx_22040895_mdu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter WORD_W, default 32, giving the operand width for word ops (wordop=1).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, unit can accept a request.
REQ-007 SHALL have port mduop_i, input, 4, operation code: 1 MUL, 2 MULH, 3 MULHSU, 4 MULHU, 5 DIV, 6 DIVU, 7 REM, 8 REMU; 0 and 9-15 are illegal.
REQ-008 SHALL have port wordop_i, input, 1, 32-bit op with sign-extended result.
REQ-009 SHALL have port op1_i, input, XLEN, rs1 value (multiplicand or dividend).
REQ-010 SHALL have port op2_i, input, XLEN, rs2 value (multiplier or divisor).
REQ-011 SHALL have port flush_i, input, 1, kills the in-flight operation.
REQ-012 SHALL have port out_valid, output, 1, result_o holds a valid result.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-014 SHALL have port result_o, output, XLEN, registered result.

Function
REQ-015 SHALL implement FSM states IDLE, CALC and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-016 SHALL accept a request on an edge with in_valid & in_ready and a legal mduop_i, latching op, wordop, operands and sign flags; an illegal op is not accepted and the FSM stays in IDLE.
REQ-017 SHALL, for a word op, sign-extend the operands' low WORD_W bits for signed ops and zero-extend them for unsigned ops.
REQ-018 SHALL honour wordop only for MUL, DIV, DIVU, REM and REMU; for MULH, MULHSU and MULHU it is ignored.
REQ-019 SHALL set the iteration count N = WORD_W when wordop applies, else XLEN.
REQ-020 SHALL compute multiplication by radix-2 shift-add, one bit per CALC cycle, on magnitudes with sign correction of the 2*XLEN product.
- MUL: low half.
- MULH, MULHSU, MULHU: high half.
REQ-021 SHALL compute division by restoring division, one quotient bit per CALC cycle, on magnitudes.
- Quotient is negated when operand signs differ.
- Remainder takes the dividend's sign.
REQ-022 SHALL load a down-counter with N on accept; in CALC the counter decrements each cycle, and CALC->DONE occurs on the edge where counter==1.
- out_valid rises exactly N cycles after the accepting edge.
REQ-023 SHALL handle special cases by going IDLE->DONE directly, so out_valid rises 1 cycle after accept:
- divide by zero: DIV/DIVU quotient = all ones; REM/REMU result = dividend.
- signed overflow (most-negative / -1): DIV result = most-negative; REM result = 0.
- Both apply at the effective width.
REQ-024 SHALL, for word ops, set result_o to the low WORD_W bits sign-extended from bit WORD_W-1; this includes DIVU/REMU.
REQ-025 SHALL hold result_o and out_valid stable in DONE until out_ready=1; on that edge the FSM goes DONE->IDLE.
REQ-026 SHALL NOT accept a new request in the same cycle a result is drained; the next accept is possible one cycle later.
REQ-027 SHALL, on flush_i=1, go to IDLE on the next edge from any state, with out_valid=0 and no result delivered.
- flush_i has priority over accept and drain.
- An in_valid in the same cycle as flush_i is not accepted.
REQ-028 SHALL keep result_o unchanged outside DONE; its value there is don't-care for consumers.

Reset
REQ-029 SHALL, on a rising edge with rst=0, set state=IDLE, counter=0, result_o=0, out_valid=0 and in_ready=1, regardless of the current state.
REQ-030 SHALL discard any in-flight operation on reset mid-operation and SHALL NOT assert out_valid for it after reset releases.

Verification
REQ-031 SHALL pass: XLEN=64, MUL, op1=7, op2=-3 -> out_valid after 64 cycles, result_o=0xFFFFFFFFFFFFFFEB.
REQ-032 SHALL pass: DIVW, op1=0x5, op2=0x0 -> out_valid after 1 cycle, result_o=0xFFFFFFFFFFFFFFFF; REMUW, same operands -> 0x0000000000000005.
REQ-033 SHALL pass: DIV, op1=0x8000000000000000, op2=-1 -> result_o=0x8000000000000000 after 1 cycle; REM with the same operands -> 0.
REQ-034 SHALL pass: REMU, op1=100, op2=7 -> result_o=2 after 64 cycles; with out_ready held low 10 cycles, out_valid and result_o stay stable and in_ready=0 throughout.
REQ-035 SHALL pass: MULHU, op1=op2=0xFFFFFFFFFFFFFFFF -> result_o=0xFFFFFFFFFFFFFFFE; with flush_i pulsed at CALC cycle 20 of a new DIV -> no out_valid, in_ready=1 next cycle.
REQ-036 SHALL pass: rst=0 for 1 cycle during CALC of DIVW -> IDLE, out_valid=0 next cycle; a following DIVW -20/3 -> result_o=0xFFFFFFFFFFFFFFFA after 32 cycles.
